// File: rtl/store_write_buffer.sv
// store_write_buffer: small store FIFO between the core's memory stage and a
// slower data RAM. Buffers stores, drains them in order over a req/ack
// handshake, flags a stall when full, and forwards the newest buffered data
// for a load address.
module store_write_buffer #(
  parameter int DATA_W = 22,
  parameter int ADDR_W = 22,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_write,
  input  logic [ADDR_W-1:0]            data_adr,
  input  logic [DATA_W-1:0]            write_data,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic [ADDR_W-1:0]            lookup_adr,
  output logic                         lookup_hit,
  output logic [DATA_W-1:0]            lookup_data,
  output logic                         wr_req,
  output logic [ADDR_W-1:0]            wr_adr,
  output logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [ADDR_W-1:0]      adr_q  [DEPTH];
  logic [ADDR_W-1:0]      adr_d  [DEPTH];
  logic [DATA_W-1:0]      data_q [DEPTH];
  logic [DATA_W-1:0]      data_d [DEPTH];
  logic                   push, pop;

  // Push/pop decisions and FIFO bookkeeping (pointers, count, entries, overflow).
  always_comb begin
    pop        = (state_q == DRAIN) && wr_ack;
    // A full buffer still accepts a store when the head leaves in the same cycle.
    push       = mem_write && ((count_q != CNT_W'(DEPTH)) || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (mem_write & ~push);
    adr_d      = adr_q;
    data_d     = data_q;
    if (push) begin
      adr_d[wr_ptr_q]  = data_adr;
      data_d[wr_ptr_q] = write_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Drain FSM next state: request while anything is buffered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (count_d != '0) state_d = DRAIN;
      DRAIN: if (pop && (count_q == CNT_W'(1)) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    adr_q  <= adr_d;
    data_q <= data_d;
  end

  // Store-to-load forwarding: walk oldest to newest so the newest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (adr_q[idx] == lookup_adr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

  // Registered-state outputs; RAM-side values are zeroed while not requesting.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    count    = count_q;
    overflow = overflow_q;
    wr_req   = (state_q == DRAIN);
    wr_adr   = wr_req ? adr_q[rd_ptr_q]  : '0;
    wr_data  = wr_req ? data_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Testbench for store_write_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_store_write_buffer;

  localparam int DATA_W = 22;
  localparam int ADDR_W = 22;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;
  logic              full;
  logic [2:0]        count;
  logic              overflow;
  logic [ADDR_W-1:0] lookup_adr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_adr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;

  store_write_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .full(full), .count(count), .overflow(overflow),
    .lookup_adr(lookup_adr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .wr_req(wr_req), .wr_adr(wr_adr), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle, then compare every output against the model.
  task automatic drive(input logic r, input logic mw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic ack,
                       input logic [ADDR_W-1:0] lk, input bit do_chk);
    logic              e_hit;
    logic [DATA_W-1:0] e_ldata;
    @(negedge clk);
    rst = r; mem_write = mw; data_adr = a; write_data = d; wr_ack = ack; lookup_adr = lk;
    #1;
    if (do_chk) begin
      e_hit = 1'b0; e_ldata = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].adr == lk) begin
          e_hit = 1'b1; e_ldata = q[i].data;
          break;
        end
      end
      chk("count",       32'(count),       32'(q.size()));
      chk("full",        32'(full),        32'(q.size() == DEPTH));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("wr_req",      32'(wr_req),      32'(q.size() != 0));
      chk("wr_adr",      32'(wr_adr),      (q.size() != 0) ? 32'(q[0].adr)  : 32'd0);
      chk("wr_data",     32'(wr_data),     (q.size() != 0) ? 32'(q[0].data) : 32'd0);
      chk("lookup_hit",  32'(lookup_hit),  32'(e_hit));
      chk("lookup_data", 32'(lookup_data), 32'(e_ldata));
    end
  endtask

  // Advance one clock edge and apply the same inputs to the model.
  task automatic tick();
    bit req, pop, push;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      req  = (q.size() != 0);
      pop  = req && wr_ack;
      push = mem_write && ((q.size() < DEPTH) || pop);
      if (mem_write && !push) m_ovf = 1'b1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{adr: data_adr, data: write_data});
    end
  endtask

  task automatic cycle(input logic r, input logic mw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic ack,
                       input logic [ADDR_W-1:0] lk);
    drive(r, mw, a, d, ack, lk, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1; mem_write = 1'b0; data_adr = '0; write_data = '0;
    wr_ack = 1'b0; lookup_adr = '0;

    // Reset held two cycles with a store strobe active.
    drive(1'b1, 1'b1, 22'h5, 22'h7, 1'b0, 22'h5, 1'b0); tick();
    cycle(1'b1, 1'b1, 22'h5, 22'h7, 1'b0, 22'h5);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h5);

    // Single store with ack tied high.
    cycle(1'b0, 1'b1, 22'h000010, 22'h2AAAAA, 1'b1, 22'h10);
    drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h10, 1'b1);
    chk("single_req", 32'(wr_req), 32'd1);
    chk("single_adr", 32'(wr_adr), 32'h10);
    chk("single_dat", 32'(wr_data), 32'h2AAAAA);
    tick();
    drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h10, 1'b1);
    chk("single_done", 32'(wr_req), 32'd0);
    tick();

    // Fill past capacity with the RAM stalled.
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 22'(i), 22'(32'h10 + i - 1), 1'b0, 22'h3);
    drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b0, 22'h5, 1'b1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full",  32'(full), 32'd1);
    chk("fill_ovf",   32'(overflow), 32'd1);
    chk("fill_nohit5", 32'(lookup_hit), 32'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h0, 1'b1);
      chk("drain_order", 32'(wr_adr), 32'(i));
      tick();
    end
    cycle(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h0);

    // Full buffer with simultaneous push and pop, wrapping pointers.
    cycle(1'b1, 1'b0, 22'h0, 22'h0, 1'b0, 22'h0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 22'(i), 22'(32'h100 + i), 1'b0, 22'h9);
    cycle(1'b0, 1'b1, 22'h9, 22'h109, 1'b1, 22'h9);
    drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h9, 1'b1);
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_ovf",   32'(overflow), 32'd0);
    chk("pp_fwd9",  32'(lookup_data), 32'h109);
    tick();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h9);

    // Forwarding with duplicate addresses.
    cycle(1'b0, 1'b1, 22'h20, 22'h1, 1'b0, 22'h20);
    cycle(1'b0, 1'b1, 22'h20, 22'h2, 1'b0, 22'h20);
    drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b0, 22'h20, 1'b1);
    chk("fwd_hit",  32'(lookup_hit), 32'd1);
    chk("fwd_data", 32'(lookup_data), 32'h2);
    tick();
    drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b0, 22'h21, 1'b1);
    chk("fwd_miss", 32'(lookup_hit), 32'd0);
    tick();
    cycle(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h20);
    drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h20, 1'b1);
    chk("fwd_after1", 32'(lookup_data), 32'h2);
    tick();
    drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b0, 22'h20, 1'b1);
    chk("fwd_after2", 32'(lookup_hit), 32'd0);
    tick();

    // Reset while draining, with ack asserted at the reset edge.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 22'(32'h40 + i), 22'(32'h50 + i), 1'b0, 22'h40);
    cycle(1'b1, 1'b0, 22'h0, 22'h0, 1'b1, 22'h40);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 22'h0, 22'h0, 1'b1, 22'h40, 1'b1);
      chk("rstmid_req", 32'(wr_req), 32'd0);
      tick();
    end

    // Random traffic over a small address range to exercise forwarding.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), 22'($urandom_range(0, 7)),
            22'($urandom), 1'($urandom), 22'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
